// File: rtl/sync_cntr3_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_cntr3_if
//  Description : Control/data bundle for the sync_cntr3 counter.
//                tc exists only when SYNCCNTR3_TC_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface sync_cntr3_if #(
    parameter int WIDTH = 3
);
    logic             cnt_en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
`ifdef SYNCCNTR3_TC_EN
    logic             tc;
`endif

`ifdef SYNCCNTR3_TC_EN
    modport master (output cnt_en, load, load_val, input count, tc);
    modport slave  (input cnt_en, load, load_val, output count, tc);
`else
    modport master (output cnt_en, load, load_val, input count);
    modport slave  (input cnt_en, load, load_val, output count);
`endif
endinterface
`default_nettype wire

// File: rtl/sync_cntr3.sv
`default_nettype none
// ============================================================================
//  Module      : sync_cntr3
//  Description : Synchronous up-counter with count enable and parallel load.
//                Priority: reset > load > cnt_en > hold. Wraps modulo 2^WIDTH.
//                Define SYNCCNTR3_TC_EN to add the registered terminal-count
//                pulse tc.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_cntr3 #(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire              clk,
    input  wire              reset,
    sync_cntr3_if.slave      cif
);

    localparam logic [WIDTH-1:0] c_CNT_MAX = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_VAL;
        end else if (cif.load) begin
            r_count <= cif.load_val;
        end else if (cif.cnt_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign cif.count = r_count;

`ifdef SYNCCNTR3_TC_EN
    logic r_tc;

    // Pulse only on a genuine increment wrap; loads/resets to zero stay quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= !cif.load && cif.cnt_en && (r_count == c_CNT_MAX);
        end
    end

    assign cif.tc = r_tc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_cntr3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_cntr3
//  Description : Scoreboard bench for sync_cntr3 (tc checked when
//                SYNCCNTR3_TC_EN is defined).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_cntr3;

    typedef struct packed {
        logic [2:0] count;
        logic       tc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    exp_t got;

    logic [2:0] m_count;

    sync_cntr3_if #(.WIDTH(3)) bus ();

    sync_cntr3 #(.WIDTH(3), .RESET_VAL(3'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one edge's controls, push the reference result, advance past the edge.
    task automatic drive_edge(input logic r, input logic e, input logic l, input logic [2:0] v);
        exp_t x;
        reset        = r;
        bus.cnt_en   = e;
        bus.load     = l;
        bus.load_val = v;
        x.tc = !r && !l && e && (m_count == 3'd7);
        if (r)      m_count = 3'd0;
        else if (l) m_count = v;
        else if (e) m_count = m_count + 3'd1;
        x.count = m_count;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_edge(1'b1, 1'b1, 1'b0, 3'd0);
        got = exp_q.pop_front();
        checks++;
        if (bus.count !== got.count) begin
            failures++;
            $display("FAIL reset_count: got %0d expected %0d", bus.count, got.count);
        end
`ifdef SYNCCNTR3_TC_EN
        checks++;
        if (bus.tc !== got.tc) begin
            failures++;
            $display("FAIL reset_tc: got %b expected %b", bus.tc, got.tc);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 1'b1, 1'b0, 3'd0);
            got = exp_q.pop_front();
            checks++;
            if (bus.count !== got.count) begin
                failures++;
                $display("FAIL reset_run[%0d]: got %0d expected %0d", i, bus.count, got.count);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            drive_edge(1'b0, (i >= 3), 1'b0, 3'd0);
            got = exp_q.pop_front();
            checks++;
            if (bus.count !== got.count) begin
                failures++;
                $display("FAIL hold[%0d]: got %0d expected %0d", i, bus.count, got.count);
            end
        end
    endtask

    task automatic test_load_wrap();
        for (int i = 0; i < 6; i++) begin
            drive_edge(1'b0, 1'b1, (i == 0), 3'b100);
            got = exp_q.pop_front();
            checks++;
            if (bus.count !== got.count) begin
                failures++;
                $display("FAIL load_wrap[%0d]: got %0d expected %0d", i, bus.count, got.count);
            end
`ifdef SYNCCNTR3_TC_EN
            checks++;
            if (bus.tc !== got.tc) begin
                failures++;
                $display("FAIL load_wrap_tc[%0d]: got %b expected %b", i, bus.tc, got.tc);
            end
`endif
        end
    endtask

    task automatic test_priority();
        drive_edge(1'b1, 1'b1, 1'b1, 3'd5);
        got = exp_q.pop_front();
        checks++;
        if (bus.count !== got.count) begin
            failures++;
            $display("FAIL prio_reset: got %0d expected %0d", bus.count, got.count);
        end
        drive_edge(1'b0, 1'b0, 1'b1, 3'd5);
        got = exp_q.pop_front();
        checks++;
        if (bus.count !== got.count) begin
            failures++;
            $display("FAIL prio_load: got %0d expected %0d", bus.count, got.count);
        end
        // Held load keeps reloading rather than counting.
        drive_edge(1'b0, 1'b1, 1'b1, 3'd5);
        got = exp_q.pop_front();
        checks++;
        if (bus.count !== got.count) begin
            failures++;
            $display("FAIL prio_reload: got %0d expected %0d", bus.count, got.count);
        end
    endtask

    task automatic test_midcount_reset();
        drive_edge(1'b0, 1'b1, 1'b0, 3'd0);
        got = exp_q.pop_front();
        checks++;
        if (bus.count !== got.count || got.count !== 3'd6) begin
            failures++;
            $display("FAIL mid_pre: got %0d expected 6", bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge((i == 0), 1'b1, 1'b0, 3'd0);
            got = exp_q.pop_front();
            checks++;
            if (bus.count !== got.count) begin
                failures++;
                $display("FAIL mid_reset[%0d]: got %0d expected %0d", i, bus.count, got.count);
            end
        end
    endtask

    task automatic test_tc();
        logic [2:0] vals[4] = '{3'd7, 3'd0, 3'd7, 3'd0};
        logic       lds[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       ens[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        // 7 -> (inc) 0 -> hold -> load 0 : tc only on the increment wrap.
        drive_edge(1'b0, 1'b0, 1'b1, 3'd6);
        void'(exp_q.pop_front());
        drive_edge(1'b0, 1'b1, 1'b0, 3'd0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b0, ens[i], lds[i], vals[i]);
            got = exp_q.pop_front();
            checks++;
            if (bus.count !== got.count) begin
                failures++;
                $display("FAIL tc_count[%0d]: got %0d expected %0d", i, bus.count, got.count);
            end
`ifdef SYNCCNTR3_TC_EN
            checks++;
            if (bus.tc !== got.tc) begin
                failures++;
                $display("FAIL tc_pulse[%0d]: got %b expected %b", i, bus.tc, got.tc);
            end
`endif
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            drive_edge(($urandom_range(15) == 0), $urandom_range(1),
                       ($urandom_range(5) == 0), 3'($urandom_range(7)));
            got = exp_q.pop_front();
            checks++;
            if (bus.count !== got.count) begin
                failures++;
                $display("FAIL random[%0d]: got %0d expected %0d", i, bus.count, got.count);
            end
`ifdef SYNCCNTR3_TC_EN
            checks++;
            if (bus.tc !== got.tc) begin
                failures++;
                $display("FAIL random_tc[%0d]: got %b expected %b", i, bus.tc, got.tc);
            end
`endif
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        m_count      = 3'd0;
        reset        = 1'b0;
        bus.cnt_en   = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 3'd0;
        @(negedge clk);
        test_reset();
        test_hold();
        test_load_wrap();
        test_priority();
        test_midcount_reset();
        test_tc();
        test_random();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        checks++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
